// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Execute-to-memory boundary of the integer pipeline. This stage consumes
// the ALU outputs (result, is_zero, ready) and owns the EX/MEM register.
//
//  * Ordinary instructions pass straight into EX/MEM unless the memory
//    stage back-pressures (mem_stall).
//  * A multiply/divide holds IF/ID/EX (ex_stall) for the whole iterative
//    latency. The single-cycle alu_ready pulse is captured in a hold buffer
//    when memory is stalled at that moment, so the result is never lost.
//  * A mul/div that never signals alu_ready is abandoned after MD_TIMEOUT
//    cycles. It retires with a zero result and raises the sticky md_timeout
//    flag, which only reset clears.
//  * Taken branches and jumps produce a one-cycle flush plus redirect_pc. The
//    control-flow instruction itself still enters EX/MEM, carrying its link
//    value for JAL/JALR.
//
// Ports
//  clk, rst_n          clock, asynchronous active-low reset
//  ex_*                instruction currently in EX (must stay stable while
//                      ex_stall=1)
//  alu_result          ALU result for the EX instruction
//  alu_is_zero         branch/jump taken indication from the ALU
//  alu_ready           one-cycle mul/div completion pulse
//  mem_stall           MEM stage cannot accept this cycle
//  ex_stall            hold IF/ID/EX
//  flush, redirect_pc  kill IF/ID and refetch from redirect_pc
//  mem_*               EX/MEM pipeline register
//  md_timeout          sticky mul/div hang indication
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int          XLEN         = 32,
    parameter int          MD_TIMEOUT   = 40,
    parameter int          CNT_W        = 6,
    // Mul/div code range of the ALU control encoding (MUL..REMU, contiguous).
    parameter logic [4:0]  ALUCTRL_MUL  = 5'd10,
    parameter logic [4:0]  ALUCTRL_REMU = 5'd17
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ex_valid,
    input  logic [4:0]      ex_ctrl,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,

    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_is_zero,
    input  logic            alu_ready,

    input  logic            mem_stall,

    output logic            ex_stall,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,

    output logic            mem_valid,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,

    output logic            md_timeout
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_PASS    = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Control-flow target. JALR clears bit 0 of the computed address.
    // Both sums wrap modulo 2^XLEN.
    function automatic logic [XLEN-1:0] branch_target(
        input logic            is_jalr,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] rs1,
        input logic [XLEN-1:0] imm
    );
        logic [XLEN-1:0] sum;
        if (is_jalr) begin
            sum = rs1 + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] ctrl);
        return (ctrl >= ALUCTRL_MUL) && (ctrl <= ALUCTRL_REMU);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  hold_q,    hold_d;
    logic             md_tmo_q,  md_tmo_d;

    logic             valid_q,   valid_d;
    logic             rwr_q,     rwr_d;
    logic             mrd_q,     mrd_d;
    logic             mwr_q,     mwr_d;
    logic [XLEN-1:0]  res_q,     res_d;
    logic [XLEN-1:0]  sdata_q,   sdata_d;
    logic [4:0]       rd_q,      rd_d;

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    logic            is_md;
    logic            is_cf;
    logic            stall_c;
    logic            flush_c;
    logic            load_c;     // EX/MEM takes the EX instruction this edge
    logic            bubble_c;   // EX/MEM takes an empty slot this edge
    logic [XLEN-1:0] load_res;

    assign is_md = ex_valid && is_muldiv(ex_ctrl);
    assign is_cf = ex_is_branch || ex_is_jal || ex_is_jalr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        md_tmo_d = md_tmo_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        load_c   = 1'b0;
        bubble_c = 1'b0;
        load_res = alu_result;

        case (state_q)
            ST_PASS: begin
                if (is_md) begin
                    // Launch cycle: the ALU starts iterating now.
                    stall_c  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_MD_WAIT;
                    bubble_c = !mem_stall;
                end else begin
                    stall_c = mem_stall;
                    load_c  = !mem_stall;
                    // Redirect only when the branch actually moves into
                    // EX/MEM, so a stalled branch cannot flush twice.
                    flush_c = load_c && ex_valid && is_cf && alu_is_zero;
                end
            end

            ST_MD_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (alu_ready) begin
                    if (!mem_stall) begin
                        load_c  = 1'b1;
                        stall_c = 1'b0;
                        state_d = ST_PASS;
                    end else begin
                        // Ready is a single pulse; keep it until MEM frees up.
                        hold_d  = alu_result;
                        state_d = ST_MD_HOLD;
                    end
                end else begin
                    bubble_c = !mem_stall;
                    if (cnt_q == CNT_LAST) begin
                        // Give up on a hung unit; retire with a zero result.
                        md_tmo_d = 1'b1;
                        hold_d   = '0;
                        state_d  = ST_MD_HOLD;
                    end
                end
            end

            ST_MD_HOLD: begin
                stall_c = 1'b1;
                if (!mem_stall) begin
                    load_c   = 1'b1;
                    load_res = hold_q;
                    stall_c  = 1'b0;
                    state_d  = ST_PASS;
                end
            end

            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // EX/MEM register next values. With neither load nor bubble (mem_stall)
    // every field holds.
    always_comb begin
        valid_d = valid_q;
        rwr_d   = rwr_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        res_d   = res_q;
        sdata_d = sdata_q;
        rd_d    = rd_q;
        if (load_c) begin
            valid_d = ex_valid;
            rwr_d   = ex_reg_write;
            mrd_d   = ex_mem_read;
            mwr_d   = ex_mem_write;
            res_d   = load_res;
            sdata_d = ex_rs2;
            rd_d    = ex_rd;
        end else if (bubble_c) begin
            // Empty slot: no side effects downstream; data fields are don't-care.
            valid_d = 1'b0;
            rwr_d   = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // EX/MEM boundary registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PASS;
            cnt_q    <= '0;
            hold_q   <= '0;
            md_tmo_q <= 1'b0;
            valid_q  <= 1'b0;
            rwr_q    <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            res_q    <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            md_tmo_q <= md_tmo_d;
            valid_q  <= valid_d;
            rwr_q    <= rwr_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            res_q    <= res_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Forced low during reset so upstream stages are not frozen by a
    // mem_stall that happens to be high while the pipeline is being reset.
    assign ex_stall    = rst_n && stall_c;
    assign flush       = rst_n && flush_c;
    assign redirect_pc = branch_target(ex_is_jalr, ex_pc, ex_rs1, ex_imm);

    assign mem_valid      = valid_q;
    assign mem_reg_write  = rwr_q;
    assign mem_mem_read   = mrd_q;
    assign mem_mem_write  = mwr_q;
    assign mem_alu_result = res_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign md_timeout     = md_tmo_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed bench for ex_mem_stage. Cycle numbering for mul/div sequences:
// cycle 0 is the cycle the mul/div is presented in EX (launch), cycle k is
// the k-th clock period after that.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int         XLEN  = 32;
    localparam logic [4:0] C_ADD = 5'd0;
    localparam logic [4:0] C_MUL = 5'd10;
    localparam logic [4:0] C_DIV = 5'd14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic [4:0]      ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic            ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [XLEN-1:0] alu_result;
    logic            alu_is_zero, alu_ready, mem_stall;
    logic            ex_stall, flush;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [XLEN-1:0] mem_alu_result, mem_store_data;
    logic [4:0]      mem_rd;
    logic            md_timeout;

    int n_total = 0;
    int n_bad   = 0;

    ex_mem_stage #(.XLEN(XLEN), .MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero), .alu_ready(alu_ready),
        .mem_stall(mem_stall),
        .ex_stall(ex_stall), .flush(flush), .redirect_pc(redirect_pc),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .md_timeout(md_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_ctrl      = C_ADD;
        ex_pc        = '0;
        ex_imm       = '0;
        ex_rs1       = '0;
        ex_rs2       = '0;
        ex_rd        = '0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
        alu_result   = '0;
        alu_is_zero  = 1'b0;
        alu_ready    = 1'b0;
    endtask

    task automatic op(input logic [4:0] ctrl, input logic [4:0] rd,
                      input logic [XLEN-1:0] res, input logic [XLEN-1:0] rs2);
        idle();
        ex_valid     = 1'b1;
        ex_ctrl      = ctrl;
        ex_rd        = rd;
        ex_reg_write = 1'b1;
        ex_rs1       = 32'd6;
        ex_rs2       = rs2;
        alu_result   = res;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // ---------------- reset -------------------------------------------
        idle();
        rst_n     = 1'b0;
        mem_stall = 1'b1;
        #12;
        check("rst_stall", ex_stall, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_res", mem_alu_result, 0);
        check("rst_tmo", md_timeout, 1'b0);
        tick();
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        tick();

        // ---------------- ADD --------------------------------------------
        op(C_ADD, 5'd3, 32'd7, 32'h11);
        #1;
        check("add_stall", ex_stall, 1'b0);
        check("add_flush", flush, 1'b0);
        tick();
        check("add_valid", mem_valid, 1'b1);
        check("add_res", mem_alu_result, 7);
        check("add_rd", mem_rd, 3);
        check("add_sdata", mem_store_data, 32'h11);

        // ---------------- MUL 6x7, no stall ------------------------------
        op(C_MUL, 5'd5, 32'd0, 32'd7);
        #1;
        check("mul_c0_stall", ex_stall, 1'b1);
        for (int c = 1; c <= 32; c++) begin
            tick();
            check("mul_wait_stall", ex_stall, 1'b1);
            check("mul_wait_bubble", mem_valid, 1'b0);
        end
        tick();                       // cycle 33
        alu_ready  = 1'b1;
        alu_result = 32'd42;
        #1;
        check("mul_c33_stall", ex_stall, 1'b0);
        tick();                       // edge 34
        idle();
        check("mul_res", mem_alu_result, 42);
        check("mul_valid", mem_valid, 1'b1);
        check("mul_rd", mem_rd, 5);
        #1;
        check("mul_after_stall", ex_stall, 1'b0);

        // ---------------- ADD then MUL with mem_stall 30..36 -------------
        op(C_ADD, 5'd3, 32'd7, 32'd0);
        tick();
        op(C_MUL, 5'd6, 32'd0, 32'd7);
        #1;
        check("mst_c0_stall", ex_stall, 1'b1);
        for (int c = 1; c <= 37; c++) begin
            tick();
            if (c == 30) mem_stall = 1'b1;
            if (c == 33) begin alu_ready = 1'b1; alu_result = 32'd42; end
            if (c == 34) begin alu_ready = 1'b0; alu_result = 32'hdead; end
            if (c == 37) mem_stall = 1'b0;
            #1;
            if (c >= 30 && c <= 36) begin
                check("mst_hold_stall", ex_stall, 1'b1);
                check("mst_hold_rd", mem_rd, 3);
                check("mst_hold_res", mem_alu_result, 7);
                check("mst_hold_valid", mem_valid, 1'b0);
            end
            if (c == 37) check("mst_release_stall", ex_stall, 1'b0);
        end
        tick();
        check("mst_res", mem_alu_result, 42);
        check("mst_rd", mem_rd, 6);
        check("mst_valid", mem_valid, 1'b1);

        // ---------------- BEQ taken, first stalled ------------------------
        idle();
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_pc        = 32'h100;
        ex_imm       = 32'h20;
        alu_is_zero  = 1'b1;
        mem_stall    = 1'b1;
        #1;
        check("beq_stall_flush", flush, 1'b0);
        check("beq_stall_exstall", ex_stall, 1'b1);
        tick();
        check("beq_stall_held_rd", mem_rd, 6);
        check("beq_stall_held_res", mem_alu_result, 42);
        mem_stall = 1'b0;
        #1;
        check("beq_flush", flush, 1'b1);
        check("beq_target", redirect_pc, 32'h120);
        check("beq_exstall", ex_stall, 1'b0);
        tick();
        check("beq_valid", mem_valid, 1'b1);
        check("beq_regwr", mem_reg_write, 1'b0);
        alu_is_zero = 1'b0;           // next branch, not taken
        #1;
        check("bne_flush", flush, 1'b0);
        tick();

        // ---------------- JALR -------------------------------------------
        idle();
        ex_valid     = 1'b1;
        ex_is_jalr   = 1'b1;
        ex_pc        = 32'h200;
        ex_rs1       = 32'h1001;
        ex_imm       = 32'h4;
        ex_rd        = 5'd1;
        ex_reg_write = 1'b1;
        alu_result   = 32'h204;
        alu_is_zero  = 1'b1;
        #1;
        check("jalr_flush", flush, 1'b1);
        check("jalr_target", redirect_pc, 32'h1004);
        tick();
        idle();
        check("jalr_link", mem_alu_result, 32'h204);
        check("jalr_rd", mem_rd, 1);
        #1;
        check("jalr_flush_once", flush, 1'b0);

        // ---------------- DIV with no alu_ready: timeout ------------------
        op(C_DIV, 5'd7, 32'h55, 32'd0);
        for (int c = 1; c <= 41; c++) begin
            tick();
            #1;
            if (c == 39) check("div_c39_tmo", md_timeout, 1'b0);
            if (c == 40) begin
                check("div_c40_tmo", md_timeout, 1'b0);
                check("div_c40_stall", ex_stall, 1'b1);
            end
            if (c == 41) begin
                check("div_c41_tmo", md_timeout, 1'b1);
                check("div_c41_stall", ex_stall, 1'b0);
            end
        end
        tick();
        idle();
        check("div_res", mem_alu_result, 0);
        check("div_rd", mem_rd, 7);
        check("div_valid", mem_valid, 1'b1);
        tick();
        check("div_tmo_sticky", md_timeout, 1'b1);

        // ---------------- reset in the middle of MD_WAIT ------------------
        op(C_ADD, 5'd9, 32'h77, 32'd0);
        tick();
        op(C_MUL, 5'd4, 32'd0, 32'd7);
        mem_stall = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("rmid_held_res", mem_alu_result, 32'h77);
        check("rmid_in_wait", ex_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_valid", mem_valid, 1'b0);
        check("rmid_res", mem_alu_result, 0);
        check("rmid_rd", mem_rd, 0);
        check("rmid_stall", ex_stall, 1'b0);
        check("rmid_tmo", md_timeout, 1'b0);
        tick();
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        op(C_ADD, 5'd2, 32'h33, 32'd0);
        #1;
        check("rpost_stall", ex_stall, 1'b0);
        tick();
        check("rpost_valid", mem_valid, 1'b1);
        check("rpost_res", mem_alu_result, 32'h33);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
